// File: rtl/lp_inst_pkr_if.sv
// lp_inst_pkr_if: loop-dispatch input group and packed downstream group bundle
interface lp_inst_pkr_if;
    logic [63:0] inst_in;
    logic [63:0] pc_in;
    logic [3:0]  inst_valid_in;
    logic        loop_strt_in;
    logic        fnsh_unrll_in;
    logic        mis_pred_in;
    logic        dwn_rdy_in;
    logic [63:0] inst_out;
    logic [63:0] pc_out;
    logic [3:0]  inst_valid_out;
    logic        grp_vld_out;
    logic        stll_ftch_out;
    logic [7:0]  grp_cnt_out;
    logic        busy_out;

    modport master (
        output inst_in, pc_in, inst_valid_in, loop_strt_in, fnsh_unrll_in, mis_pred_in, dwn_rdy_in,
        input  inst_out, pc_out, inst_valid_out, grp_vld_out, stll_ftch_out, grp_cnt_out, busy_out
    );

    modport slave (
        input  inst_in, pc_in, inst_valid_in, loop_strt_in, fnsh_unrll_in, mis_pred_in, dwn_rdy_in,
        output inst_out, pc_out, inst_valid_out, grp_vld_out, stll_ftch_out, grp_cnt_out, busy_out
    );
endinterface

// File: rtl/lp_inst_pkr.sv
// lp_inst_pkr: compacts sparse loop instruction slots into dense 4-wide groups via a 16-entry FIFO
module lp_inst_pkr (
    input  logic clk,
    input  logic rst,
    lp_inst_pkr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem [16];
    logic [4:0]  count, count_nxt;
    logic [3:0]  rd_ptr, wr_ptr;
    logic [7:0]  grp_cnt;
    logic [2:0]  vcnt, enq, deq, avail;
    logic [1:0]  off [4];
    logic        enq_en, grp_vld, stll, xfer;
    logic [63:0] inst_o, pc_o;
    logic [3:0]  vld_o;

    // next-state, occupancy arithmetic and combinational head presentation
    always_comb begin
        stll = state == PACK && count > 5'd12;
        enq_en = !bus.mis_pred_in && ((state == IDLE && bus.loop_strt_in) || (state == PACK && !stll));
        vcnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            off[i] = vcnt[1:0];
            vcnt = vcnt + {2'b0, bus.inst_valid_in[3-i]};
        end
        enq = enq_en ? vcnt : 3'd0;
        grp_vld = !bus.mis_pred_in && ((state == PACK && count >= 5'd4) || (state == DRAIN && count != 5'd0));
        avail = count >= 5'd4 ? 3'd4 : count[2:0];
        xfer = grp_vld && bus.dwn_rdy_in;
        deq = xfer ? avail : 3'd0;
        count_nxt = bus.mis_pred_in ? 5'd0 : count + 5'(enq) - 5'(deq);
        state_nxt = state;
        if (bus.mis_pred_in)
            state_nxt = IDLE;
        else if (state == IDLE && bus.loop_strt_in)
            state_nxt = PACK;
        else if (state == PACK && bus.fnsh_unrll_in && !stll)
            state_nxt = DRAIN;
        else if (state == DRAIN && count_nxt == 5'd0)
            state_nxt = IDLE;
        inst_o = '0;
        pc_o = '0;
        vld_o = '0;
        for (int j = 0; j < 4; j++) begin
            if (grp_vld && 3'(j) < avail) begin
                inst_o[63-16*j -: 16] = mem[rd_ptr + 4'(j)][31:16];
                pc_o[63-16*j -: 16] = mem[rd_ptr + 4'(j)][15:0];
                vld_o[3-j] = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // occupancy, pointers and transfer counter; misprediction flushes but keeps the group count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            grp_cnt <= '0;
        end else begin
            count <= count_nxt;
            rd_ptr <= bus.mis_pred_in ? 4'd0 : rd_ptr + 4'(deq);
            wr_ptr <= bus.mis_pred_in ? 4'd0 : wr_ptr + 4'(enq);
            if (!bus.mis_pred_in && state == IDLE && bus.loop_strt_in)
                grp_cnt <= '0;
            else if (xfer && grp_cnt != 8'hff)
                grp_cnt <= grp_cnt + 8'd1;
        end
    end

    // valid slots land in consecutive entries, oldest slot first
    always_ff @(posedge clk) begin
        if (enq_en)
            for (int i = 0; i < 4; i++)
                if (bus.inst_valid_in[3-i])
                    mem[wr_ptr + 4'(off[i])] <= {bus.inst_in[63-16*i -: 16], bus.pc_in[63-16*i -: 16]};
    end

    assign bus.inst_out = inst_o;
    assign bus.pc_out = pc_o;
    assign bus.inst_valid_out = vld_o;
    assign bus.grp_vld_out = grp_vld;
    assign bus.stll_ftch_out = stll;
    assign bus.grp_cnt_out = grp_cnt;
    assign bus.busy_out = state != IDLE;
endmodule

// File: tb/tb_lp_inst_pkr.sv
// tb_lp_inst_pkr: table vectors, corner sequences and random traffic against a queue-based model
module tb_lp_inst_pkr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errs = 0;
    int checks = 0;

    localparam int M_IDLE = 0, M_PACK = 1, M_DRAIN = 2;
    logic [31:0] q[$];
    int mode = M_IDLE;
    int gcnt = 0;

    typedef struct {
        logic [3:0] vm;
        logic       ls, fin, mis, rdy;
        logic [3:0] ivo;
        logic       gv, st, busy;
        logic [7:0] gc;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    lp_inst_pkr_if bus();
    lp_inst_pkr dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] vm, input logic ls, input logic fin, input logic mis, input logic rdy);
        bus.inst_in = {$urandom, $urandom};
        bus.pc_in = {$urandom, $urandom};
        bus.inst_valid_in = vm;
        bus.loop_strt_in = ls;
        bus.fnsh_unrll_in = fin;
        bus.mis_pred_in = mis;
        bus.dwn_rdy_in = rdy;
    endtask

    task automatic check_model();
        int n = q.size();
        int k;
        logic gv;
        logic [63:0] ei = '0;
        logic [63:0] ep = '0;
        logic [3:0] ev = '0;
        gv = !bus.mis_pred_in && ((mode == M_PACK && n >= 4) || (mode == M_DRAIN && n > 0));
        k = gv ? (n < 4 ? n : 4) : 0;
        for (int j = 0; j < k; j++) begin
            ei[63-16*j -: 16] = q[j][31:16];
            ep[63-16*j -: 16] = q[j][15:0];
            ev[3-j] = 1'b1;
        end
        chk("inst_out", bus.inst_out, ei);
        chk("pc_out", bus.pc_out, ep);
        chk("inst_valid_out", 64'(bus.inst_valid_out), 64'(ev));
        chk("grp_vld_out", 64'(bus.grp_vld_out), 64'(gv));
        chk("stll_ftch_out", 64'(bus.stll_ftch_out), 64'(mode == M_PACK && n > 12));
        chk("grp_cnt_out", 64'(bus.grp_cnt_out), 64'(gcnt));
        chk("busy_out", 64'(bus.busy_out), 64'(mode != M_IDLE));
    endtask

    task automatic model_step();
        int n = q.size();
        logic stall = mode == M_PACK && n > 12;
        logic gv = (mode == M_PACK && n >= 4) || (mode == M_DRAIN && n > 0);
        if (bus.mis_pred_in) begin
            q.delete();
            mode = M_IDLE;
            return;
        end
        if (gv && bus.dwn_rdy_in) begin
            repeat (n < 4 ? n : 4) void'(q.pop_front());
            if (gcnt < 255) gcnt++;
        end
        if ((mode == M_IDLE && bus.loop_strt_in) || (mode == M_PACK && !stall))
            for (int i = 0; i < 4; i++)
                if (bus.inst_valid_in[3-i])
                    q.push_back({bus.inst_in[63-16*i -: 16], bus.pc_in[63-16*i -: 16]});
        if (mode == M_IDLE && bus.loop_strt_in) begin
            mode = M_PACK;
            gcnt = 0;
        end else if (mode == M_PACK && bus.fnsh_unrll_in && !stall)
            mode = M_DRAIN;
        else if (mode == M_DRAIN && q.size() == 0)
            mode = M_IDLE;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        q.delete();
        mode = M_IDLE;
        gcnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[2]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[4]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5]  = '{4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 8'd2};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd3};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd3};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[10] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[11] = '{4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0};

        drive(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vm, tbl[i].ls, tbl[i].fin, tbl[i].mis, tbl[i].rdy);
            @(negedge clk);
            check_model();
            chk($sformatf("tbl%0d_valid", i), 64'(bus.inst_valid_out), 64'(tbl[i].ivo));
            chk($sformatf("tbl%0d_grp_vld", i), 64'(bus.grp_vld_out), 64'(tbl[i].gv));
            chk($sformatf("tbl%0d_stall", i), 64'(bus.stll_ftch_out), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_busy", i), 64'(bus.busy_out), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_grp_cnt", i), 64'(bus.grp_cnt_out), 64'(tbl[i].gc));
            advance();
        end

        do_reset();
        drive(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (3) begin
            drive(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_model();
        chk("stall_at_12", 64'(bus.stll_ftch_out), 64'd0);
        advance();
        @(negedge clk);
        check_model();
        chk("stall_at_16", 64'(bus.stll_ftch_out), 64'd1);
        advance();
        @(negedge clk);
        check_model();
        chk("stall_held", 64'(bus.stll_ftch_out), 64'd1);
        advance();
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_model();
        chk("stall_full_grp", 64'(bus.inst_valid_out), 64'hf);
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_model();
        chk("stall_release", 64'(bus.stll_ftch_out), 64'd0);
        advance();

        do_reset();
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        repeat (300) begin
            drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_model();
        chk("grp_cnt_sat", 64'(bus.grp_cnt_out), 64'd255);
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_model();
        chk("grp_cnt_clr", 64'(bus.grp_cnt_out), 64'd0);
        advance();

        do_reset();
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_model();
        chk("drain_offer", 64'(bus.grp_vld_out), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_grp_vld", 64'(bus.grp_vld_out), 64'd0);
        chk("async_busy", 64'(bus.busy_out), 64'd0);
        chk("async_valid", 64'(bus.inst_valid_out), 64'd0);
        chk("async_inst", bus.inst_out, 64'd0);
        q.delete();
        mode = M_IDLE;
        gcnt = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        tick();

        for (int c = 0; c < 3000; c++) begin
            drive(4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
